// File: rtl/kmkz_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kmkz_ahb_arbiter
// Brief    : Shares one AHB-Lite master port between the I and D requesters,
//            re-issuing each registered request as a SINGLE/NONSEQ transfer.
// Revision : 1.0 - initial release
// ============================================================================
module kmkz_ahb_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PRIO_D = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [2:0]        hburst_i,
    input  logic [3:0]        hprot_i,
    input  logic              hmastlock_i,
    input  logic [DATA_W-1:0] hwdata_i,
    output logic [DATA_W-1:0] hrdata_i,
    output logic              hready_i,
    output logic              hresp_i,
    input  logic [ADDR_W-1:0] haddr_d,
    input  logic [1:0]        htrans_d,
    input  logic              hwrite_d,
    input  logic [2:0]        hsize_d,
    input  logic [2:0]        hburst_d,
    input  logic [3:0]        hprot_d,
    input  logic              hmastlock_d,
    input  logic [DATA_W-1:0] hwdata_d,
    output logic [DATA_W-1:0] hrdata_d,
    output logic              hready_d,
    output logic              hresp_d,
    output logic [ADDR_W-1:0] haddr_m,
    output logic [1:0]        htrans_m,
    output logic              hwrite_m,
    output logic [2:0]        hsize_m,
    output logic [2:0]        hburst_m,
    output logic [3:0]        hprot_m,
    output logic              hmastlock_m,
    output logic [DATA_W-1:0] hwdata_m,
    input  logic [DATA_W-1:0] hrdata_m,
    input  logic              hready_m,
    input  logic              hresp_m
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic       c_prio_port     = (PRIO_D != 0);

    // Index 0 is the I port, index 1 is the D port.
    logic [1:0][ADDR_W-1:0] w_req_addr;
    logic [1:0][1:0]        w_req_trans;
    logic [1:0]             w_req_write;
    logic [1:0][2:0]        w_req_size;
    logic [1:0][3:0]        w_req_prot;
    logic [1:0]             w_req_lock;

    state_t            r_state [2];
    logic [ADDR_W-1:0] r_addr  [2];
    logic [2:0]        r_size  [2];
    logic [3:0]        r_prot  [2];
    logic [1:0]        r_write;
    logic [1:0]        r_lock;

    logic [1:0]        w_cand;
    logic [1:0]        w_port_ready;
    logic [1:0]        w_accept;
    logic [1:0]        w_issue;
    logic              w_gnt_vld;
    logic              w_gnt;
    logic              r_lk_vld;
    logic              r_lk_port;

    logic [ADDR_W-1:0] r_hold_addr;
    logic              r_hold_write;
    logic [2:0]        r_hold_size;
    logic [3:0]        r_hold_prot;
    logic              r_hold_lock;

    logic              w_unused_ok;

    assign w_req_addr  = {haddr_d, haddr_i};
    assign w_req_trans = {htrans_d, htrans_i};
    assign w_req_write = {hwrite_d, hwrite_i};
    assign w_req_size  = {hsize_d, hsize_i};
    assign w_req_prot  = {hprot_d, hprot_i};
    assign w_req_lock  = {hmastlock_d, hmastlock_i};

    // Burst type and the low HTRANS bit (SEQ vs NONSEQ, BUSY vs IDLE) carry no meaning here.
    assign w_unused_ok = ^{hburst_i, hburst_d, htrans_i[0], htrans_d[0]};

    assign w_cand       = {r_state[1] == ST_PEND, r_state[0] == ST_PEND};
    assign w_port_ready = {(r_state[1] == ST_IDLE) | ((r_state[1] == ST_DATA) & hready_m),
                           (r_state[0] == ST_IDLE) | ((r_state[0] == ST_DATA) & hready_m)};
    assign w_accept     = w_port_ready & {w_req_trans[1][1], w_req_trans[0][1]};

    // A stalled address phase keeps its grant, so priority cannot pre-empt it.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        if (r_lk_vld) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_lk_port;
        end else if (&w_cand) begin
            w_gnt_vld = 1'b1;
            w_gnt     = c_prio_port;
        end else if (w_cand[1]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
        end else if (w_cand[0]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b0;
        end
    end

    assign w_issue = {w_gnt_vld &  w_gnt & hready_m,
                      w_gnt_vld & ~w_gnt & hready_m};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= ST_IDLE;
                r_addr[p]  <= '0;
                r_size[p]  <= '0;
                r_prot[p]  <= '0;
            end
            r_write <= '0;
            r_lock  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_accept[p]) begin
                    r_state[p] <= ST_PEND;
                    r_addr[p]  <= w_req_addr[p];
                    r_size[p]  <= w_req_size[p];
                    r_prot[p]  <= w_req_prot[p];
                    r_write[p] <= w_req_write[p];
                    r_lock[p]  <= w_req_lock[p];
                end else if (w_issue[p]) begin
                    r_state[p] <= ST_DATA;
                end else if ((r_state[p] == ST_DATA) && hready_m) begin
                    r_state[p] <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lk_vld     <= 1'b0;
            r_lk_port    <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_write <= 1'b0;
            r_hold_size  <= '0;
            r_hold_prot  <= '0;
            r_hold_lock  <= 1'b0;
        end else begin
            r_lk_vld     <= w_gnt_vld & ~hready_m;
            r_lk_port    <= w_gnt;
            r_hold_addr  <= haddr_m;
            r_hold_write <= hwrite_m;
            r_hold_size  <= hsize_m;
            r_hold_prot  <= hprot_m;
            r_hold_lock  <= hmastlock_m;
        end
    end

    // Without a winner the address bus parks on its last value.
    assign htrans_m    = w_gnt_vld ? c_htrans_nonseq : c_htrans_idle;
    assign haddr_m     = w_gnt_vld ? r_addr[w_gnt]   : r_hold_addr;
    assign hwrite_m    = w_gnt_vld ? r_write[w_gnt]  : r_hold_write;
    assign hsize_m     = w_gnt_vld ? r_size[w_gnt]   : r_hold_size;
    assign hprot_m     = w_gnt_vld ? r_prot[w_gnt]   : r_hold_prot;
    assign hmastlock_m = w_gnt_vld ? r_lock[w_gnt]   : r_hold_lock;
    assign hburst_m    = 3'b000;

    always_comb begin
        hwdata_m = '0;
        if (r_state[1] == ST_DATA) begin
            hwdata_m = hwdata_d;
        end else if (r_state[0] == ST_DATA) begin
            hwdata_m = hwdata_i;
        end
    end

    assign hrdata_i = hrdata_m;
    assign hrdata_d = hrdata_m;
    assign hready_i = w_port_ready[0];
    assign hready_d = w_port_ready[1];
    assign hresp_i  = (r_state[0] == ST_DATA) & hresp_m;
    assign hresp_d  = (r_state[1] == ST_DATA) & hresp_m;

endmodule
`default_nettype wire

// File: tb/tb_kmkz_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kmkz_ahb_arbiter
// Brief    : Directed scenarios plus randomized traffic against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kmkz_ahb_arbiter;

    localparam int c_prio_d = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] haddr_i, haddr_d, hwdata_i, hwdata_d, hrdata_m;
    logic [1:0]  htrans_i, htrans_d;
    logic        hwrite_i, hwrite_d, hmastlock_i, hmastlock_d, hready_m, hresp_m;
    logic [2:0]  hsize_i, hsize_d, hburst_i, hburst_d;
    logic [3:0]  hprot_i, hprot_d;
    logic [31:0] hrdata_i, hrdata_d, haddr_m, hwdata_m;
    logic        hready_i, hready_d, hresp_i, hresp_d, hwrite_m, hmastlock_m;
    logic [1:0]  htrans_m;
    logic [2:0]  hsize_m, hburst_m;
    logic [3:0]  hprot_m;

    int errors = 0;
    int checks = 0;

    kmkz_ahb_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_D(c_prio_d)) dut (
        .clk(clk), .rst(rst),
        .haddr_i(haddr_i), .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i),
        .hburst_i(hburst_i), .hprot_i(hprot_i), .hmastlock_i(hmastlock_i), .hwdata_i(hwdata_i),
        .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i),
        .haddr_d(haddr_d), .htrans_d(htrans_d), .hwrite_d(hwrite_d), .hsize_d(hsize_d),
        .hburst_d(hburst_d), .hprot_d(hprot_d), .hmastlock_d(hmastlock_d), .hwdata_d(hwdata_d),
        .hrdata_d(hrdata_d), .hready_d(hready_d), .hresp_d(hresp_d),
        .haddr_m(haddr_m), .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hsize_m(hsize_m),
        .hburst_m(hburst_m), .hprot_m(hprot_m), .hmastlock_m(hmastlock_m), .hwdata_m(hwdata_m),
        .hrdata_m(hrdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        haddr_i = '0; htrans_i = 2'b00; hwrite_i = 1'b0; hsize_i = 3'd2; hburst_i = 3'd0;
        hprot_i = 4'h3; hmastlock_i = 1'b0; hwdata_i = '0;
        haddr_d = '0; htrans_d = 2'b00; hwrite_d = 1'b0; hsize_d = 3'd2; hburst_d = 3'd0;
        hprot_d = 4'h3; hmastlock_d = 1'b0; hwdata_d = '0;
        hrdata_m = '0; hready_m = 1'b1; hresp_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released: cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({htrans_m, hready_i, hready_d, hresp_i, hresp_d} !== 6'b00_1100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 001100", {htrans_m, hready_i, hready_d, hresp_i, hresp_d});
        end
        checks++;
        if ({haddr_m, hwrite_m, hsize_m, hburst_m, hprot_m, hmastlock_m, hwdata_m} !== 76'd0) begin
            errors++;
            $display("FAIL reset_addr: addr=%h wr=%b size=%h burst=%h prot=%h lock=%b wdata=%h want all zero",
                     haddr_m, hwrite_m, hsize_m, hburst_m, hprot_m, hmastlock_m, hwdata_m);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        htrans_d = 2'b10; haddr_d = 32'h2000_0100;
        tick();
        htrans_d = 2'b00;
        #2;
        checks++;
        if (htrans_m !== 2'b10) begin
            errors++;
            $display("FAIL reset_pre: htrans_m got %b want 10", htrans_m);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({htrans_m, hready_i, hready_d, hresp_i, hresp_d} !== 6'b00_1100) begin
            errors++;
            $display("FAIL reset_mid: got %b want 001100", {htrans_m, hready_i, hready_d, hresp_i, hresp_d});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        htrans_d = 2'b10; haddr_d = 32'h2000_0010; hwrite_d = 1'b0; hrdata_m = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({htrans_m, hready_d} !== 3'b00_1) begin
            errors++;
            $display("FAIL single_c0: htrans_m=%b hready_d=%b want 00 1", htrans_m, hready_d);
        end
        tick();
        htrans_d = 2'b00;
        @(negedge clk);
        checks++;
        if ({htrans_m, haddr_m, hwrite_m, hburst_m, hready_d} !== {2'b10, 32'h2000_0010, 1'b0, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL single_c1: htrans=%b addr=%h wr=%b burst=%h hready_d=%b want 10 20000010 0 0 0",
                     htrans_m, haddr_m, hwrite_m, hburst_m, hready_d);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({hready_d, hrdata_d, htrans_m, haddr_m} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 32'h2000_0010}) begin
            errors++;
            $display("FAIL single_c2: hready_d=%b hrdata_d=%h htrans=%b addr=%h want 1 deadbeef 00 20000010",
                     hready_d, hrdata_d, htrans_m, haddr_m);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        htrans_i = 2'b10; haddr_i = 32'h0000_0100; hwrite_i = 1'b0; hwdata_i = 32'h1111_2222;
        htrans_d = 2'b10; haddr_d = 32'h2000_0000; hwrite_d = 1'b1;
        tick();
        htrans_i = 2'b00; htrans_d = 2'b00; hwdata_d = 32'hCAFE_0001;
        @(negedge clk);
        checks++;
        if ({htrans_m, haddr_m, hwrite_m, hready_i, hready_d} !== {2'b10, 32'h2000_0000, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL simul_c1: htrans=%b addr=%h wr=%b rdy_i=%b rdy_d=%b want 10 20000000 1 0 0",
                     htrans_m, haddr_m, hwrite_m, hready_i, hready_d);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({htrans_m, haddr_m, hwrite_m, hwdata_m, hready_i, hready_d} !==
            {2'b10, 32'h0000_0100, 1'b0, 32'hCAFE_0001, 2'b01}) begin
            errors++;
            $display("FAIL simul_c2: htrans=%b addr=%h wr=%b wdata=%h rdy_i=%b rdy_d=%b want 10 00000100 0 cafe0001 0 1",
                     htrans_m, haddr_m, hwrite_m, hwdata_m, hready_i, hready_d);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({htrans_m, hwdata_m, hready_i} !== {2'b00, 32'h1111_2222, 1'b1}) begin
            errors++;
            $display("FAIL simul_c3: htrans=%b wdata=%h rdy_i=%b want 00 11112222 1", htrans_m, hwdata_m, hready_i);
        end
        tick();
        @(negedge clk);
        checks++;
        if (hwdata_m !== 32'h0) begin
            errors++;
            $display("FAIL simul_c4: hwdata_m got %h want 0", hwdata_m);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        htrans_i = 2'b10; haddr_i = 32'h0000_0300;
        tick();
        htrans_i = 2'b00; hready_m = 1'b0;
        htrans_d = 2'b10; haddr_d = 32'h2000_0040;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({htrans_m, haddr_m} !== {2'b10, 32'h0000_0300}) begin
                errors++;
                $display("FAIL wait_hold_c%0d: htrans=%b addr=%h want 10 00000300", c, htrans_m, haddr_m);
            end
            tick();
            htrans_d = 2'b00;
        end
        hready_m = 1'b1;
        @(negedge clk);
        checks++;
        if ({htrans_m, haddr_m} !== {2'b10, 32'h0000_0300}) begin
            errors++;
            $display("FAIL wait_c4: htrans=%b addr=%h want 10 00000300", htrans_m, haddr_m);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({htrans_m, haddr_m, hready_i} !== {2'b10, 32'h2000_0040, 1'b1}) begin
            errors++;
            $display("FAIL wait_c5: htrans=%b addr=%h rdy_i=%b want 10 20000040 1", htrans_m, haddr_m, hready_i);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({htrans_m, hready_d} !== 3'b00_1) begin
            errors++;
            $display("FAIL wait_c6: htrans=%b rdy_d=%b want 00 1", htrans_m, hready_d);
        end
    endtask

    task automatic test_error();
        do_reset();
        htrans_d = 2'b10; haddr_d = 32'h2000_0020;
        tick();
        htrans_d = 2'b00;
        tick();
        hready_m = 1'b0; hresp_m = 1'b1;
        @(negedge clk);
        checks++;
        if ({hresp_d, hready_d, hresp_i} !== 3'b100) begin
            errors++;
            $display("FAIL error_c1: resp_d=%b rdy_d=%b resp_i=%b want 1 0 0", hresp_d, hready_d, hresp_i);
        end
        tick();
        hready_m = 1'b1;
        @(negedge clk);
        checks++;
        if ({hresp_d, hready_d, hresp_i} !== 3'b110) begin
            errors++;
            $display("FAIL error_c2: resp_d=%b rdy_d=%b resp_i=%b want 1 1 0", hresp_d, hready_d, hresp_i);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({hresp_d, hresp_i} !== 2'b00) begin
            errors++;
            $display("FAIL error_after: resp_d=%b resp_i=%b want 0 0 (not data owner)", hresp_d, hresp_i);
        end
        hresp_m = 1'b0;
    endtask

    task automatic test_starvation();
        int done_c;
        done_c = -1;
        do_reset();
        htrans_i = 2'b10; haddr_i = 32'h0000_0400;
        htrans_d = 2'b10; haddr_d = 32'h2000_0080;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) htrans_i = 2'b00;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (haddr_m !== 32'h2000_0080) begin
                    errors++;
                    $display("FAIL starve_prio: haddr_m got %h want 20000080", haddr_m);
                end
            end
            if (hready_i === 1'b1 && done_c < 0) done_c = c;
        end
        checks++;
        if (done_c < 1 || done_c > 4) begin
            errors++;
            $display("FAIL starve_bound: I completed at cycle %0d want 1..4", done_c);
        end
        htrans_d = 2'b00;
    endtask

    // Transaction model: a request waits in a per-port slot until some address phase carries it,
    // then owns the data phase until the slave says ready.
    task automatic test_random(input int n);
        bit          slot_v [2];
        logic [31:0] slot_a [2];
        bit          slot_w [2];
        logic [2:0]  slot_s [2];
        logic [3:0]  slot_p [2];
        bit          slot_l [2];
        bit          owner  [2];
        bit          may_req[2];
        bit          stall_v;
        int          stall_p;
        logic [45:0] park;
        logic [45:0] exp_a, got_a;
        logic [99:0] exp_b, got_b;
        logic [1:0]  tr     [2];
        logic [31:0] ra     [2];
        bit          rw     [2];
        logic [2:0]  rs     [2];
        logic [3:0]  rp     [2];
        bit          rl     [2];
        bit          rdy    [2];
        bit          gv;
        int          g;
        logic [31:0] wd;

        do_reset();
        for (int p = 0; p < 2; p++) begin
            slot_v[p] = 0; owner[p] = 0; may_req[p] = 1;
            slot_a[p] = '0; slot_w[p] = 0; slot_s[p] = '0; slot_p[p] = '0; slot_l[p] = 0;
        end
        stall_v = 0; stall_p = 0; park = '0;

        for (int c = 0; c < n; c++) begin
            if (may_req[0]) begin
                htrans_i = 2'($urandom_range(0, 3)); haddr_i = $urandom; hwrite_i = 1'($urandom);
                hsize_i = 3'($urandom); hprot_i = 4'($urandom); hmastlock_i = 1'($urandom);
                hburst_i = 3'($urandom);
            end
            if (may_req[1]) begin
                htrans_d = 2'($urandom_range(0, 3)); haddr_d = $urandom; hwrite_d = 1'($urandom);
                hsize_d = 3'($urandom); hprot_d = 4'($urandom); hmastlock_d = 1'($urandom);
                hburst_d = 3'($urandom);
            end
            hwdata_i = $urandom; hwdata_d = $urandom; hrdata_m = $urandom;
            hready_m = ($urandom_range(0, 3) != 0);
            hresp_m  = ($urandom_range(0, 7) == 0);
            @(negedge clk);

            tr[0] = htrans_i; ra[0] = haddr_i; rw[0] = hwrite_i; rs[0] = hsize_i; rp[0] = hprot_i; rl[0] = hmastlock_i;
            tr[1] = htrans_d; ra[1] = haddr_d; rw[1] = hwrite_d; rs[1] = hsize_d; rp[1] = hprot_d; rl[1] = hmastlock_d;

            for (int p = 0; p < 2; p++) rdy[p] = slot_v[p] ? 1'b0 : (owner[p] ? hready_m : 1'b1);

            gv = 1; g = 0;
            if (stall_v) g = stall_p;
            else if (slot_v[0] && slot_v[1]) g = c_prio_d;
            else if (slot_v[1]) g = 1;
            else if (slot_v[0]) g = 0;
            else gv = 0;

            exp_a = gv ? {2'b10, slot_a[g], slot_w[g], slot_s[g], 3'b000, slot_p[g], slot_l[g]}
                       : {2'b00, park[43:0]};
            wd = owner[1] ? hwdata_d : (owner[0] ? hwdata_i : 32'h0);
            exp_b = {wd, rdy[0], rdy[1], owner[0] & hresp_m, owner[1] & hresp_m, hrdata_m, hrdata_m};
            got_a = {htrans_m, haddr_m, hwrite_m, hsize_m, hburst_m, hprot_m, hmastlock_m};
            got_b = {hwdata_m, hready_i, hready_d, hresp_i, hresp_d, hrdata_i, hrdata_d};

            checks++;
            if (got_a !== exp_a) begin
                errors++;
                $display("FAIL rand_addr cyc=%0d: got %h want %h", c, got_a, exp_a);
            end
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL rand_resp cyc=%0d: got %h want %h", c, got_b, exp_b);
            end

            park = exp_a;
            stall_v = gv && !hready_m;
            stall_p = g;
            for (int p = 0; p < 2; p++) begin
                if (owner[p] && hready_m) owner[p] = 0;
                if (gv && g == p && hready_m) begin
                    slot_v[p] = 0;
                    owner[p]  = 1;
                end
                if (rdy[p] && tr[p][1]) begin
                    slot_v[p] = 1; slot_a[p] = ra[p]; slot_w[p] = rw[p];
                    slot_s[p] = rs[p]; slot_p[p] = rp[p]; slot_l[p] = rl[p];
                end
                may_req[p] = rdy[p];
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_wait_states();
        test_error();
        test_starvation();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
